ex_muldiv_unit: RTL and testbench
=================================

# ex_muldiv_unit

Parametrised multi-cycle multiply/divide unit that sits beside the ALU in the EX stage and owns the architectural HI/LO register pair. It accepts one operation per start pulse and holds busy to stall the pipeline while it runs. It signals completion with a one-cycle done pulse, at which point HI/LO hold the result. A pipeline flush aborts any in-flight operation without touching HI/LO.

## Interface
- W, default 64: operand and HI/LO width (power of two, ≥8).
- MUL_LAT, default 2: multiply latency in cycles when fast multiply is compiled in (≥1).
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high.
- start  in  1  issue request; sampled only in IDLE.
- op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6–7 ignored (no state change).
- a  in  W  operand A (already forwarded by EX).
- b  in  W  operand B (already forwarded by EX).
- flush  in  1  abort in-flight op.
- busy  out  1  op in progress; EX stall request.
- done  out  1  one-cycle pulse, HI/LO valid this cycle.
- div_by_zero  out  1  qualifies done for DIV/DIVU with b==0.
- hi  out  W  HI register.
- lo  out  W  LO register.

## Operation
- Reset (asynchronous) forces state=IDLE, hi=0, lo=0, busy=0, done=0, div_by_zero=0.
- States: IDLE, MUL, DIV, FIX.
- IDLE, start, op MTHI: hi←a at the next edge. For op MTLO: lo←a at the next edge. Neither raises busy or done.
- IDLE, start, op MULT/MULTU → MUL. For op DIV/DIVU → DIV. Operands are latched. Signed ops latch magnitudes and the result signs: product sign = a[W-1]^b[W-1]; quotient sign likewise; remainder sign = a[W-1].
- MUL, iterative: shift-add, one multiplier bit per cycle, W cycles, then → FIX.
- DIV: restoring division on magnitudes, one quotient bit per cycle, W cycles, then → FIX.
- FIX: applies two's-complement sign correction, writes the result, pulses done, → IDLE.
  - Multiply result: {hi,lo} = 2W-bit product.
  - Divide result: lo = quotient, hi = remainder.
- Divide by zero (b==0, signed or unsigned): full latency; result lo=all ones, hi=a (original, unsigned); div_by_zero=1 with done.
- Signed overflow (a=most-negative, b=−1): lo=most-negative, hi=0; no flag.
- busy=1 in MUL, DIV and FIX, and during the fast-multiply pipeline; otherwise 0.
- start while busy: ignored (the EX stage must hold the instruction); the bench asserts this never happens.
- flush: in any state, state→IDLE at the next edge; no done; hi/lo unchanged.
- flush together with start in IDLE: flush wins; nothing issued, no MTHI/MTLO write.
- flush in the same cycle as FIX: write suppressed, done not asserted.

## Timing
- Start sampled at edge N.
  - Iterative MUL/DIV: busy=1 from after edge N. done=1 and new hi/lo visible after edge N+W+1; busy=0 in that same cycle. For W=64, that is 65 cycles.
  - Fast MUL: done and result after edge N+MUL_LAT.
- MTHI/MTLO: hi/lo visible after edge N; zero stall.
- Back-to-back: a new start is accepted in the cycle done=1, because busy=0 there.
- done and div_by_zero are registered and high for exactly one cycle.
- hi/lo change only on a completing op, MTHI/MTLO, or reset.

## Configuration
- MULDIV_FAST_MUL_EN defined:
  - MULT/MULTU use a synthesised W×W multiplier followed by a MUL_LAT-stage output pipeline; the FIX cycle is not used.
  - flush invalidates all pipeline stages.
- Undefined: iterative shift-add multiply (W+1 cycles). MUL_LAT is unused.
- DIV is always iterative.

## Test plan
- Reset mid-DIV: assert reset at cycle 10 of a DIVU → immediately busy=0, hi=lo=0; a DIVU started afterwards completes correctly.
- DIVU a=100, b=7 (W=64) → after 65 cycles: done=1, lo=14, hi=2, div_by_zero=0.
- DIV a=−100, b=7 → lo=−14, hi=−2. DIV a=0x8000_0000_0000_0000, b=−1 → lo=0x8000_0000_0000_0000, hi=0.
- MULT a=−3, b=5 → {hi,lo}=−15 (hi=all ones, lo=0xFFFF_FFFF_FFFF_FFF1). MULTU a=b=all ones → hi=0xFFFF_FFFF_FFFF_FFFE, lo=1. Check latency 65 cycles without the macro and MUL_LAT with it.
- DIVU a=42, b=0 → done with div_by_zero=1, lo=all ones, hi=42.
- MTHI a=5 then MTLO a=9 on consecutive cycles → hi=5, lo=9, busy never high. Then start a DIV and flush at cycle 30 → busy=0 next cycle, no done, hi=5, lo=9 retained.

Source files
------------

// File: rtl/ex_muldiv_unit.sv
// EX-stage multiply/divide unit owning the HI/LO pair: iterative shift-add multiply and restoring divide.
// Define MULDIV_FAST_MUL_EN to replace the iterative multiply with a W x W multiplier plus MUL_LAT output stages.
module ex_muldiv_unit #(
  parameter int W       = 64,
  parameter int MUL_LAT = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         flush,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIX  = 2'd3;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam int            CW   = $clog2(W) + 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  function automatic logic [W-1:0] magnitude(input logic [W-1:0] x, input logic is_signed);
    return (is_signed && x[W-1]) ? -x : x;
  endfunction

  function automatic logic [W-1:0] negate_if(input logic [W-1:0] x, input logic neg);
    return neg ? -x : x;
  endfunction

  function automatic logic [2*W-1:0] negate2_if(input logic [2*W-1:0] x, input logic neg);
    return neg ? -x : x;
  endfunction

  logic [1:0]     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic           done_q, done_d, dbz_q, dbz_d;
  logic [2*W-1:0] pr_q, pr_d;
  logic [W-1:0]   opb_q, opb_d, a_q, a_d;
  logic           is_div_q, is_div_d, neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d;

  logic           sgn_op, issue, fast_busy, fast_done, fast_mul;
  logic [W-1:0]   a_mag, b_mag;
  logic [2*W-1:0] fast_prod;
  logic [W:0]     mul_sum, rem_shift, trial;

  assign sgn_op = (op == OP_MULT) || (op == OP_DIV);
  assign a_mag  = magnitude(a, sgn_op);
  assign b_mag  = magnitude(b, sgn_op);
  assign issue  = start && !flush && (state_q == S_IDLE) && !fast_busy;

  // Multiply step: conditionally add the multiplicand to the upper half, then shift the pair right.
  assign mul_sum   = {1'b0, pr_q[2*W-1:W]} + (pr_q[0] ? {1'b0, opb_q} : {(W+1){1'b0}});
  // Divide step: shift the next dividend bit into the remainder and try subtracting the divisor.
  assign rem_shift = {pr_q[2*W-1:W], pr_q[W-1]};
  assign trial     = rem_shift - {1'b0, opb_q};

`ifdef MULDIV_FAST_MUL_EN
  logic [MUL_LAT-1:0] mvld_q, mvld_d;
  logic [2*W-1:0]     mprod_q [MUL_LAT];
  logic [2*W-1:0]     mprod_d [MUL_LAT];
  logic [2*W-1:0]     ext_a, ext_b;
  logic               issue_mul;

  assign fast_mul  = 1'b1;
  assign issue_mul = issue && ((op == OP_MULT) || (op == OP_MULTU));
  // Sign- or zero-extending to 2W makes the truncated 2W product exact for both signednesses.
  assign ext_a = {{W{sgn_op & a[W-1]}}, a};
  assign ext_b = {{W{sgn_op & b[W-1]}}, b};

  always_comb begin
    mvld_d     = '0;
    mprod_d[0] = ext_a * ext_b;
    for (int i = 1; i < MUL_LAT; i++) mprod_d[i] = mprod_q[i-1];
    if (!flush) begin
      mvld_d[0] = issue_mul;
      for (int i = 1; i < MUL_LAT; i++) mvld_d[i] = mvld_q[i-1];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) mvld_q <= '0;
    else       mvld_q <= mvld_d;
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < MUL_LAT; i++) mprod_q[i] <= mprod_d[i];
  end

  assign fast_busy = |mvld_q;
  assign fast_done = mvld_q[MUL_LAT-1] && !flush;
  assign fast_prod = mprod_q[MUL_LAT-1];
`else
  assign fast_mul  = 1'b0;
  assign fast_busy = (MUL_LAT < 0);
  assign fast_done = 1'b0;
  assign fast_prod = '0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    dbz_d    = 1'b0;
    pr_d     = pr_q;
    opb_d    = opb_q;
    a_d      = a_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;

    if (issue) begin
      case (op)
        OP_MTHI: hi_d = a;
        OP_MTLO: lo_d = a;
        OP_MULT, OP_MULTU: begin
          if (!fast_mul) begin
            state_d  = S_MUL;
            cnt_d    = '0;
            is_div_d = 1'b0;
            pr_d     = {{W{1'b0}}, b_mag};
            opb_d    = a_mag;
            neg_d    = sgn_op & (a[W-1] ^ b[W-1]);
          end
        end
        OP_DIV, OP_DIVU: begin
          state_d  = S_DIV;
          cnt_d    = '0;
          is_div_d = 1'b1;
          pr_d     = {{W{1'b0}}, a_mag};
          opb_d    = b_mag;
          neg_d    = sgn_op & (a[W-1] ^ b[W-1]);
          rneg_d   = sgn_op & a[W-1];
          a_d      = a;
          dz_d     = (b == '0);
        end
        default: ;
      endcase
    end

    case (state_q)
      S_MUL: begin
        pr_d  = {mul_sum, pr_q[W-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = S_FIX;
      end
      S_DIV: begin
        pr_d  = {(trial[W] ? rem_shift[W-1:0] : trial[W-1:0]), pr_q[W-2:0], ~trial[W]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!flush) begin
          done_d = 1'b1;
          if (!is_div_q) begin
            {hi_d, lo_d} = negate2_if(pr_q, neg_q);
          end else if (dz_q) begin
            lo_d  = '1;
            hi_d  = a_q;
            dbz_d = 1'b1;
          end else begin
            lo_d = negate_if(pr_q[W-1:0], neg_q);
            hi_d = negate_if(pr_q[2*W-1:W], rneg_q);
          end
        end
      end
      default: ;
    endcase

    if (fast_done) begin
      {hi_d, lo_d} = fast_prod;
      done_d       = 1'b1;
    end

    if (flush) state_d = S_IDLE;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  always_ff @(posedge clock) begin
    pr_q     <= pr_d;
    opb_q    <= opb_d;
    a_q      <= a_d;
    is_div_q <= is_div_d;
    neg_q    <= neg_d;
    rneg_q   <= rneg_d;
    dz_q     <= dz_d;
  end

  assign busy        = (state_q != S_IDLE) || fast_busy;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: expected HI/LO, flag and latency queued at issue, checked on done.
module tb_ex_muldiv_unit;
  localparam int W       = 64;
  localparam int MUL_LAT = 2;
`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  localparam logic [2:0] OP_MULT = 3'd0, OP_MULTU = 3'd1, OP_DIV = 3'd2, OP_DIVU = 3'd3;
  localparam logic [2:0] OP_MTHI = 3'd4, OP_MTLO = 3'd5;
  localparam logic [W-1:0] ONES = '1;
  localparam logic [W-1:0] MIN  = {1'b1, {(W-1){1'b0}}};

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   op    = '0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         flush = 1'b0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  ex_muldiv_unit #(.W(W), .MUL_LAT(MUL_LAT)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    logic [31:0]  lat;
  } exp_t;

  exp_t         exp_q[$];
  int           n_checks = 0;
  int           n_errors = 0;
  logic [W-1:0] cur_hi, cur_lo;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    logic signed [2*W-1:0] sp;
    logic [2*W-1:0]        up;
    e.dbz = 1'b0;
    e.lat = W + 1;
    e.hi  = '0;
    e.lo  = '0;
    case (o)
      OP_MULT: begin
        sp = $signed(x) * $signed(y);
        {e.hi, e.lo} = sp;
        if (FAST) e.lat = MUL_LAT;
      end
      OP_MULTU: begin
        up = x * y;
        {e.hi, e.lo} = up;
        if (FAST) e.lat = MUL_LAT;
      end
      default: begin
        if (y == '0) begin
          e.lo  = ONES;
          e.hi  = x;
          e.dbz = 1'b1;
        end else if (o == OP_DIV && x == MIN && y == ONES) begin
          e.lo = MIN;
          e.hi = '0;
        end else if (o == OP_DIV) begin
          e.lo = $signed(x) / $signed(y);
          e.hi = $signed(x) % $signed(y);
        end else begin
          e.lo = x / y;
          e.hi = x % y;
        end
      end
    endcase
    return e;
  endfunction

  // Drive a single start pulse at a negedge; returns one negedge later (start sampled in between).
  task automatic start_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    chk("idle_at_start", busy, 1'b0);
    if (o <= OP_DIVU) exp_q.push_back(model(o, x, y));
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(negedge clock);
    start = 1'b0;
    if (o <= OP_DIVU) chk("busy_after_start", busy, 1'b1);
  endtask

  task automatic wait_done();
    exp_t e;
    bit   seen = 1'b0;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clock);
      if (done) begin
        e = exp_q.pop_front();
        chk("latency", c, e.lat);
        chk("hi", hi, e.hi);
        chk("lo", lo, e.lo);
        chk("div_by_zero", div_by_zero, e.dbz);
        chk("busy_at_done", busy, 1'b0);
        cur_hi = e.hi;
        cur_lo = e.lo;
        seen   = 1'b1;
        break;
      end
    end
    if (!seen) begin
      chk("done_timeout", 1'b0, 1'b1);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
  endtask

  task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    start_op(o, x, y);
    wait_done();
  endtask

  initial begin
    logic       any_done;
    logic [2:0] rop;
    logic [W-1:0] ra, rb;

    repeat (2) @(negedge clock);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_dbz", div_by_zero, 1'b0);
    chk("rst_hi", hi, '0);
    chk("rst_lo", lo, '0);
    reset = 1'b0;
    @(negedge clock);

    // MTHI then MTLO on consecutive cycles: zero stall.
    chk("mt_idle", busy, 1'b0);
    start = 1'b1; op = OP_MTHI; a = 64'd5;
    @(negedge clock);
    chk("mthi_hi", hi, 64'd5);
    chk("mthi_busy", busy, 1'b0);
    chk("mthi_done", done, 1'b0);
    op = OP_MTLO; a = 64'd9;
    @(negedge clock);
    start = 1'b0;
    chk("mtlo_hi", hi, 64'd5);
    chk("mtlo_lo", lo, 64'd9);
    chk("mtlo_busy", busy, 1'b0);
    chk("mtlo_done", done, 1'b0);
    cur_hi = 64'd5;
    cur_lo = 64'd9;

    // DIV flushed at cycle 30: no done, HI/LO retained.
    start_op(OP_DIV, 64'd1000, 64'd3);
    void'(exp_q.pop_front());
    any_done = 1'b0;
    repeat (29) begin
      @(negedge clock);
      any_done |= done;
    end
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    chk("flush_busy", busy, 1'b0);
    for (int i = 0; i < 80; i++) begin
      @(negedge clock);
      any_done |= done;
    end
    chk("flush_no_done", any_done, 1'b0);
    chk("flush_hi", hi, cur_hi);
    chk("flush_lo", lo, cur_lo);

    // Asynchronous reset in the middle of a DIVU.
    start_op(OP_DIVU, 64'd12345, 64'd11);
    void'(exp_q.pop_front());
    repeat (10) @(negedge clock);
    #1 reset = 1'b1;
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_hi", hi, '0);
    chk("midrst_lo", lo, '0);
    chk("midrst_done", done, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    run_op(OP_DIVU, 64'd12345, 64'd11);

    // Directed arithmetic, issued back to back in each done cycle.
    run_op(OP_DIVU, 64'd100, 64'd7);
    run_op(OP_DIV, -64'sd100, 64'd7);
    run_op(OP_DIV, MIN, ONES);
    run_op(OP_MULT, -64'sd3, 64'd5);
    run_op(OP_MULTU, ONES, ONES);
    run_op(OP_DIVU, 64'd42, 64'd0);
    run_op(OP_DIV, -64'sd42, 64'd0);
    run_op(OP_MULT, MIN, MIN);
    run_op(OP_DIV, 64'd7, -64'sd100);

    for (int i = 0; i < 10; i++) begin
      rop = 3'($urandom_range(0, 3));
      ra  = {$urandom, $urandom};
      rb  = (i % 3 == 0) ? W'($urandom_range(1, 1000)) : {$urandom, $urandom};
      run_op(rop, ra, rb);
    end

    // Flush landing on the result-write cycle: no write, no done.
    start_op(OP_DIVU, 64'd77, 64'd5);
    void'(exp_q.pop_front());
    any_done = 1'b0;
    repeat (W) begin
      @(negedge clock);
      any_done |= done;
    end
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    any_done |= done;
    chk("fixflush_done", any_done, 1'b0);
    chk("fixflush_busy", busy, 1'b0);
    chk("fixflush_hi", hi, cur_hi);
    chk("fixflush_lo", lo, cur_lo);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
